// File: rtl/neuraedge_tile_pkg.sv
// Purpose: shared types and constants for the neuraedge systolic tile (sequencer + PE array).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package neuraedge_tile_pkg;

    localparam int NE_ACC_W  = 32;
    localparam int NE_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } tile_seq_state_t;

endpackage

// File: rtl/neuraedge_tile_drain_ctl.sv
// Purpose: row counter and readout handshake for the accumulator drain phase.
// Latency: drain_row advances the cycle after each drain_valid&drain_ready handshake.
// Backpressure: drain_ready=0 holds drain_row stable; last_done fires on the final row handshake.
// Ports: active (sequencer is in DRAIN), drain_ready (sink accepts), drain_valid/drain_row to sink,
//        last_done to the sequencer FSM.
module neuraedge_tile_drain_ctl #(
    parameter int ROWS  = 4,
    parameter int ROW_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             drain_ready,
    output logic             drain_valid,
    output logic [ROW_W-1:0] drain_row,
    output logic             last_done
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [ROW_W-1:0] rcnt;
    logic             drain_hs;

    assign drain_hs    = active & drain_ready;
    assign drain_valid = active;
    assign drain_row   = rcnt;
    assign last_done   = drain_hs & (rcnt == LAST_ROW);

    // Counter is forced to 0 outside DRAIN so every drain starts at row 0,
    // even if the previous one was cut short by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
        end else if (!active) begin
            rcnt <= '0;
        end else if (drain_hs) begin
            rcnt <= (rcnt == LAST_ROW) ? '0 : rcnt + 1'b1;
        end
    end

endmodule

// File: rtl/neuraedge_tile_seq.sv
// Purpose: sequencer for one ROWSxCOLS systolic tile; drives broadcast PE control lines per command.
// Latency: 1 (CLEAR, if cmd_acc=0) + k_len beats + ROWS+COLS-2 flush + ROWS drain beats + 1 done.
// Backpressure: FEED stalls on in_valid=0; DRAIN stalls on drain_ready=0; cmd_ready only when idle.
// Ports: cmd_valid/cmd_ready/cmd_k_len/cmd_acc (command), in_valid/in_ready (operand feeder),
//        pe_enable/mac_clear/accumulate_en/data_valid (PE array), drain_valid/drain_ready/drain_row
//        (readout), busy, done. Build option NE_TILE_SEQ_PERF_EN adds perf_busy_cyc/perf_stall_cyc.
module neuraedge_tile_seq
    import neuraedge_tile_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 16,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [K_W-1:0]   cmd_k_len,
    input  logic             cmd_acc,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             pe_enable,
    output logic             mac_clear,
    output logic             accumulate_en,
    output logic             data_valid,
    output logic             drain_valid,
    input  logic             drain_ready,
    output logic [ROW_W-1:0] drain_row,
    output logic             busy,
`ifdef NE_TILE_SEQ_PERF_EN
    output logic [31:0]      perf_busy_cyc,
    output logic [31:0]      perf_stall_cyc,
`endif
    output logic             done
);

    // Cycles for the last operand to skew across to the far-corner PE.
    localparam int              FLUSH_LEN  = ROWS + COLS - 2;
    localparam int              F_W        = $clog2(ROWS + COLS);
    localparam logic [F_W-1:0]  FLUSH_LAST = F_W'(FLUSH_LEN - 1);
    // A 1x1 array has no skew to flush.
    localparam tile_seq_state_t POST_FEED  = (FLUSH_LEN == 0) ? DRAIN : FLUSH;

    tile_seq_state_t state, state_nxt;
    logic [K_W-1:0]  k_len_q;
    logic [K_W-1:0]  kcnt;
    logic [F_W-1:0]  fcnt;
    logic            feed_hs;
    logic            feed_last;
    logic            flush_last;
    logic            drain_last;
    logic            cmd_hs;

    assign cmd_hs     = cmd_valid & cmd_ready;
    assign feed_hs    = (state == FEED) & in_valid;
    assign feed_last  = feed_hs & (kcnt == k_len_q - 1'b1);
    assign flush_last = (state == FLUSH) & (fcnt == FLUSH_LAST);
    assign busy       = (state != IDLE);
    // Reset already forces IDLE; gating keeps cmd_ready low until rst is released.
    assign cmd_ready  = (state == IDLE) & ~rst;

    neuraedge_tile_drain_ctl #(
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_drain_ctl (
        .clk         (clk),
        .rst         (rst),
        .active      (state == DRAIN),
        .drain_ready (drain_ready),
        .drain_valid (drain_valid),
        .drain_row   (drain_row),
        .last_done   (drain_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            k_len_q <= '0;
            kcnt    <= '0;
            fcnt    <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_hs) begin
                k_len_q <= cmd_k_len;
            end
            if (feed_hs) begin
                kcnt <= feed_last ? '0 : kcnt + 1'b1;
            end
            if (state == FLUSH) begin
                fcnt <= flush_last ? '0 : fcnt + 1'b1;
            end else begin
                fcnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        pe_enable     = 1'b0;
        mac_clear     = 1'b0;
        accumulate_en = 1'b0;
        data_valid    = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_hs) begin
                    if (!cmd_acc)             state_nxt = CLEAR;
                    else if (cmd_k_len == '0) state_nxt = DRAIN;
                    else                      state_nxt = FEED;
                end
            end
            CLEAR: begin
                pe_enable = 1'b1;
                mac_clear = 1'b1;
                state_nxt = (k_len_q == '0) ? DRAIN : FEED;
            end
            FEED: begin
                in_ready      = 1'b1;
                pe_enable     = 1'b1;
                // Operand beat and its MAC enable travel together, no register stage.
                accumulate_en = in_valid;
                data_valid    = in_valid;
                if (feed_last) state_nxt = POST_FEED;
            end
            FLUSH: begin
                pe_enable     = 1'b1;
                accumulate_en = 1'b1;
                if (flush_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef NE_TILE_SEQ_PERF_EN
    logic stall_cyc;
    assign stall_cyc = ((state == FEED) & ~in_valid) | ((state == DRAIN) & ~drain_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && (perf_busy_cyc != '1)) begin
                perf_busy_cyc <= perf_busy_cyc + 1'b1;
            end
            if (stall_cyc && (perf_stall_cyc != '1)) begin
                perf_stall_cyc <= perf_stall_cyc + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_neuraedge_tile_seq.sv
// Purpose: self-checking bench for neuraedge_tile_seq (4x4 tile, directed command scenarios).
// Latency: expected per-cycle output vectors are queued by the stimulus and popped by a monitor.
// Backpressure: exercised through in_valid gaps and drain_ready stalls.
module tb_neuraedge_tile_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_k_len = '0;
    logic        cmd_acc = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        pe_enable;
    logic        mac_clear;
    logic        accumulate_en;
    logic        data_valid;
    logic        drain_valid;
    logic        drain_ready = 1'b0;
    logic [1:0]  drain_row;
    logic        busy;
    logic        done;
`ifdef NE_TILE_SEQ_PERF_EN
    logic [31:0] perf_busy_cyc;
    logic [31:0] perf_stall_cyc;
    logic [31:0] stall_base;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    logic [10:0] exp_q[$];
    logic [10:0] obs;
    logic [10:0] exp_v;

    // {busy, cmd_ready, in_ready, pe_enable, mac_clear, accumulate_en, data_valid,
    //  drain_valid, drain_row[1:0], done}
    localparam logic [10:0] IDLE_V = 11'b010_0000_0000;
    localparam logic [10:0] CR_M   = 11'b010_0000_0000;

    assign obs = {busy, cmd_ready, in_ready, pe_enable, mac_clear, accumulate_en,
                  data_valid, drain_valid, drain_row, done};

    always #5 clk = ~clk;

    neuraedge_tile_seq #(.ROWS(4), .COLS(4), .K_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_k_len     (cmd_k_len),
        .cmd_acc       (cmd_acc),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pe_enable     (pe_enable),
        .mac_clear     (mac_clear),
        .accumulate_en (accumulate_en),
        .data_valid    (data_valid),
        .drain_valid   (drain_valid),
        .drain_ready   (drain_ready),
        .drain_row     (drain_row),
        .busy          (busy),
`ifdef NE_TILE_SEQ_PERF_EN
        .perf_busy_cyc (perf_busy_cyc),
        .perf_stall_cyc(perf_stall_cyc),
`endif
        .done          (done)
    );

    function automatic logic [10:0] v_clear();
        return 11'b100_1100_0000;
    endfunction
    function automatic logic [10:0] v_feed(input bit v);
        return {4'b1011, 1'b0, v, v, 1'b0, 2'b00, 1'b0};
    endfunction
    function automatic logic [10:0] v_flush();
        return 11'b100_1010_0000;
    endfunction
    function automatic logic [10:0] v_drain(input logic [1:0] row);
        return {7'b1000000, 1'b1, row, 1'b0};
    endfunction
    function automatic logic [10:0] v_done();
        return 11'b100_0000_0001;
    endfunction

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s t=%0t got %b required %b", name, $time, got, req);
        end
    endtask

    // Monitor: every busy cycle must match the next queued vector; idle cycles show IDLE_V.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL seq_extra t=%0t got busy vector %b required idle (nothing queued)",
                             $time, obs);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("seq", obs, exp_v);
                end
            end else begin
                chk("idle", obs, IDLE_V);
            end
        end
    end

    // Issue one command and queue the per-cycle expectations of the whole busy window.
    // inpat/drpat: bit i is in_valid / drain_ready on the i-th FEED / DRAIN cycle.
    task automatic run_cmd(input int k, input bit acc, input logic [31:0] inpat,
                           input logic [31:0] drpat, input bit hold);
        int  beats;
        int  i;
        int  r;
        bit  v;
        bit  d;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_k_len = 16'(k); cmd_acc = acc;
        in_valid = 1'b0; drain_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = hold;
        if (!acc) begin
            exp_q.push_back(v_clear());
            @(posedge clk); #1;
        end
        beats = 0;
        i = 0;
        while (beats < k) begin
            v = (i < 32) ? inpat[i] : 1'b1;
            in_valid = v;
            exp_q.push_back(v_feed(v));
            if (v) beats++;
            i++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (k > 0) begin
            for (int f = 0; f < 6; f++) begin
                exp_q.push_back(v_flush());
                @(posedge clk); #1;
            end
        end
        r = 0;
        i = 0;
        while (r < 4) begin
            d = (i < 32) ? drpat[i] : 1'b1;
            drain_ready = d;
            exp_q.push_back(v_drain(2'(r)));
            if (d) r++;
            i++;
            @(posedge clk); #1;
        end
        drain_ready = 1'b0;
        cmd_valid = 1'b0;
        exp_q.push_back(v_done());
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset held from time 0.
        #2;
        chk("rst_hold", obs & ~CR_M, 11'b0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("post_rst", obs, IDLE_V);
        // Reset pulse in the middle of idle.
        @(posedge clk); #2; rst = 1'b1;
        #1; chk("rst_idle_pulse", obs & ~CR_M, 11'b0);
        #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_pulse", obs, IDLE_V);

        mon_en = 1'b1;
        // Basic 4x4 command: clear c1, feed c2-4, flush c5-10, drain c11-14, done c15.
        run_cmd(3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        // Operand gaps: in_valid 1,0,0,1,1,0,1,1 -> 5 beats over 8 cycles.
`ifdef NE_TILE_SEQ_PERF_EN
        stall_base = perf_stall_cyc;
`endif
        run_cmd(5, 1'b0, 32'hFFFF_FFD9, 32'hFFFF_FFFF, 1'b0);
`ifdef NE_TILE_SEQ_PERF_EN
        checks++;
        if (perf_stall_cyc - stall_base != 32'd3) begin
            errors++;
            $display("FAIL perf_feed_stall got %0d required 3", perf_stall_cyc - stall_base);
        end
        stall_base = perf_stall_cyc;
`endif
        // Drain stall: ready 1,1,0,0,0,1,1 -> row 2 held for 3 cycles.
        run_cmd(2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE3, 1'b0);
`ifdef NE_TILE_SEQ_PERF_EN
        checks++;
        if (perf_stall_cyc - stall_base != 32'd3) begin
            errors++;
            $display("FAIL perf_drain_stall got %0d required 3", perf_stall_cyc - stall_base);
        end
`endif
        // Accumulate mode (no clear) with cmd_valid held high through the busy window.
        run_cmd(2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        // Zero-length reductions: straight to drain, with and without clear.
        run_cmd(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_cmd(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Asynchronous reset during the second FEED beat.
        @(negedge clk);
        mon_en = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_k_len = 16'd5; cmd_acc = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(negedge clk); chk("rst_case_clear", obs, v_clear());
        @(posedge clk); #1;
        @(negedge clk); chk("rst_case_feed1", obs, v_feed(1'b1));
        @(posedge clk); #2; rst = 1'b1;
        #1; chk("rst_async_feed", obs & ~CR_M, 11'b0);
        @(negedge clk); #1; rst = 1'b0; in_valid = 1'b0;
        @(negedge clk); chk("rst_feed_idle", obs, IDLE_V);
        @(negedge clk); chk("rst_feed_idle2", obs, IDLE_V);

        // Recovery with the shortest non-zero reduction.
        mon_en = 1'b1;
        run_cmd(1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect got %0d queued entries required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
